mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
//
// PURPOSE
// - Shares one downstream memory port between the core's imem (fetch) and dmem (load/store) requesters.
// - Protocol is the core's req/gnt bus: a transfer is accepted when req && gnt.
// - err/rdata for an accepted transfer are valid exactly one cycle after the accept.
// - Sits between the core and the single-ported SRAM/MMIO fabric in the SoC top.
// - Fixed priority to dmem, with a starvation limit that guarantees imem progress.
//
// PARAMETERS
// - MEM_ADDR_W  64  address width (all ports)
// - MEM_STRB_W   8  write strobe width
// - MEM_DATA_W  64  data width
// - MAX_STARVE   4  consecutive dmem accepts while imem waits before imem is forced to win; legal 1..15
//
// PORTS
// - g_clk         in   1        global clock
// - g_reset       in   1        synchronous, active-high reset
// - imem_req      in   1        imem request
// - imem_addr     in   ADDR_W   imem address
// - imem_wen      in   1        imem write enable
// - imem_strb     in   STRB_W   imem write strobe
// - imem_wdata    in   DATA_W   imem write data
// - imem_gnt      out  1        imem request accepted this cycle
// - imem_err      out  1        imem response error (cycle after accept)
// - imem_rdata    out  DATA_W   imem response data (cycle after accept)
// - dmem_*        same set and directions as imem_*, for the data requester
// - m_req         out  1        downstream request
// - m_addr        out  ADDR_W   downstream address
// - m_wen         out  1        downstream write enable
// - m_strb        out  STRB_W   downstream strobe
// - m_wdata       out  DATA_W   downstream write data
// - m_gnt         in   1        downstream accept
// - m_err         in   1        downstream response error
// - m_rdata       in   DATA_W   downstream response data
//
// BEHAVIOUR
// - Reset: while g_reset=1, the following are 0 and all state clears (FSM=IDLE, starve_cnt=0, rsp_vld=0):
//   - m_req, both *_gnt, both *_err, both *_rdata.
// - Reset mid-transfer: any outstanding response is dropped and not forwarded.
// - FSM, states IDLE, HOLD_I, HOLD_D:
//   - IDLE: winner = imem if (imem_req && (!dmem_req || starve_cnt==MAX_STARVE)); else dmem if dmem_req.
//     - Winner's request fields are muxed combinationally onto m_*.
//     - m_req=0 when there is no requester.
//     - If winner && !m_gnt, go to HOLD_<winner>.
//   - HOLD_x: m_* driven from x only; the selection is locked regardless of the other requester.
//     - m_gnt=1: accept, go to IDLE.
//     - x_req=0 (illegal withdrawal): m_req drops the same cycle, go to IDLE.
// - Grant: x_gnt = m_gnt && m_req && (selected==x). Never both high. Zero added latency.
// - Response routing: on accept, register rsp_vld=1 and rsp_own=x; otherwise rsp_vld=0.
//   - Next cycle: x_err = rsp_vld && rsp_own==x && m_err, x_rdata = m_rdata gated the same way.
//   - The non-owner sees err=0 and rdata=0.
//   - Back-to-back accepts are legal: a response and a new accept in the same cycle for different owners.
// - Starvation counter (width 4):
//   - +1 on each dmem accept while imem_req=1, saturating at MAX_STARVE.
//   - Clears to 0 on imem accept or when imem_req=0.
//   - Both counter events in one cycle: clear wins.
// - Combinational paths: m_gnt->*_gnt; *_req/*_addr->m_*. No path from m_gnt to m_req.
//
// STRUCTURE
// - Package mem_bus_pkg:
//   - typedef enum {OWN_IMEM, OWN_DMEM} mem_owner_t;
//   - typedef enum {ARB_IDLE, ARB_HOLD_I, ARB_HOLD_D} arb_state_t;
//   - width localparams.
// - Sub-module mem_arb_starve_ctr holds the saturating starvation counter and its force_imem output.
// - FSM, request mux and response router stay in mem_bus_arbiter.
//
// TESTING
// - Both request in IDLE with m_gnt=1 and starve_cnt=0 -> dmem_gnt=1, imem_gnt=0, m_addr=dmem_addr.
//   - Next cycle m_rdata=64'hCAFE goes to dmem_rdata; imem_rdata=0.
// - Both request continuously with m_gnt=1 and MAX_STARVE=4 -> dmem accepts in cycles 1-4, imem accepts in cycle 5, dmem wins again in cycle 6.
// - imem alone with m_gnt=0 for 3 cycles, dmem_req rises in cycle 2, m_gnt=1 in cycle 4.
//   - Expected: m_addr stays imem_addr throughout, imem_gnt=1 in cycle 4 only, dmem accepted in cycle 5.
// - dmem accepted in cycle N with m_err=1 in N+1, imem accepted in N+1.
//   - Expected: dmem_err=1, imem_err=0 in N+1; imem response routed in N+2.
// - g_reset asserted the cycle after an accept -> no *_err/*_rdata forwarded, all outputs 0, FSM IDLE.
// - Request withdrawn in HOLD_D (dmem_req 1->0, m_gnt=0) -> m_req=0 the same cycle; a pending imem_req is arbitrated next cycle.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the imem/dmem memory-bus arbiter.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_STRB_W = 8;
  localparam int DEF_DATA_W = 64;
  localparam int STARVE_W   = 4;

  // Which requester owns the downstream port (or the pending response).
  typedef enum logic {
    OWN_IMEM,
    OWN_DMEM
  } mem_owner_t;

  // IDLE arbitrates; HOLD_x locks the selection while x waits for m_gnt.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HOLD_I,
    ARB_HOLD_D
  } arb_state_t;

endpackage

// File: rtl/mem_bus_if.sv
// req/gnt memory bus: the request fields travel master->slave, while
// gnt/err/rdata travel back. err/rdata belong to the transfer accepted
// one cycle earlier.
interface mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STRB_W = DEF_STRB_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, addr, wen, strb, wdata,
    input  gnt, err, rdata
  );

  modport slave (
    input  req, addr, wen, strb, wdata,
    output gnt, err, rdata
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of dmem accepts taken while imem was waiting. When it
// reaches MAX_STARVE, imem is forced to win the next arbitration.
module mem_arb_starve_ctr
  import mem_bus_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic g_clk,
  input  logic g_reset,
  input  logic imem_req,
  input  logic imem_acc,
  input  logic dmem_acc,
  output logic force_imem
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] cnt_reg;
  logic [STARVE_W-1:0] cnt_next;

  // Clearing beats counting when both happen in one cycle.
  always_comb begin
    cnt_next = cnt_reg;
    if (imem_acc || !imem_req) begin
      cnt_next = '0;
    end else if (dmem_acc && (cnt_reg != LIMIT)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign force_imem = (cnt_reg == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between imem (fetch) and dmem
// (load/store). dmem has fixed priority, and a starvation counter
// guarantees imem progress. Grants are combinational from m_gnt, and
// responses are routed to whichever requester was accepted last cycle.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int MEM_ADDR_W = DEF_ADDR_W,
  parameter int MEM_STRB_W = DEF_STRB_W,
  parameter int MEM_DATA_W = DEF_DATA_W,
  parameter int MAX_STARVE = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  mem_bus_if.slave    imem,
  mem_bus_if.slave    dmem,
  mem_bus_if.master   m
);

  arb_state_t state_reg, state_next;
  mem_owner_t sel;
  logic       sel_vld;
  logic       req_out;
  logic       accept;
  logic       force_imem;

  mem_owner_t rsp_own_reg;
  logic       rsp_vld_reg;
  logic       rsp_live;

  logic [MEM_ADDR_W-1:0] mux_addr;
  logic [MEM_STRB_W-1:0] mux_strb;
  logic [MEM_DATA_W-1:0] mux_wdata;
  logic [MEM_DATA_W-1:0] rsp_rdata;

  // Pick the owner of the port and decide the next FSM state.
  always_comb begin
    state_next = state_reg;
    sel        = OWN_DMEM;
    sel_vld    = 1'b0;
    unique case (state_reg)
      ARB_IDLE: begin
        if (imem.req && (!dmem.req || force_imem)) begin
          sel     = OWN_IMEM;
          sel_vld = 1'b1;
        end else if (dmem.req) begin
          sel     = OWN_DMEM;
          sel_vld = 1'b1;
        end
      end
      ARB_HOLD_I: begin
        sel     = OWN_IMEM;
        sel_vld = imem.req;
      end
      ARB_HOLD_D: begin
        sel     = OWN_DMEM;
        sel_vld = dmem.req;
      end
      default: begin
        sel     = OWN_DMEM;
        sel_vld = 1'b0;
      end
    endcase

    // m_req depends only on the requesters, never on m_gnt.
    req_out = sel_vld && !g_reset;
    accept  = req_out && m.gnt;

    if (state_reg == ARB_IDLE) begin
      if (req_out && !m.gnt) begin
        state_next = (sel == OWN_IMEM) ? ARB_HOLD_I : ARB_HOLD_D;
      end
    end else if (!sel_vld || m.gnt) begin
      // Either accepted, or the held requester withdrew.
      state_next = ARB_IDLE;
    end
  end

  // FSM state and the one-deep record of who owns next cycle's response.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_reg   <= ARB_IDLE;
      rsp_vld_reg <= 1'b0;
      rsp_own_reg <= OWN_IMEM;
    end else begin
      state_reg   <= state_next;
      rsp_vld_reg <= accept;
      rsp_own_reg <= sel;
    end
  end

  mem_arb_starve_ctr #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .imem_req   (imem.req),
    .imem_acc   (accept && (sel == OWN_IMEM)),
    .dmem_acc   (accept && (sel == OWN_DMEM)),
    .force_imem (force_imem)
  );

  // Request mux: the selected requester drives the downstream port.
  assign mux_addr  = (sel == OWN_IMEM) ? imem.addr  : dmem.addr;
  assign mux_strb  = (sel == OWN_IMEM) ? imem.strb  : dmem.strb;
  assign mux_wdata = (sel == OWN_IMEM) ? imem.wdata : dmem.wdata;

  assign m.req   = req_out;
  assign m.addr  = mux_addr;
  assign m.wen   = (sel == OWN_IMEM) ? imem.wen : dmem.wen;
  assign m.strb  = mux_strb;
  assign m.wdata = mux_wdata;

  assign imem.gnt = accept && (sel == OWN_IMEM);
  assign dmem.gnt = accept && (sel == OWN_DMEM);

  // Response router: a response held over a reset is dropped.
  assign rsp_live  = rsp_vld_reg && !g_reset;
  assign rsp_rdata = m.rdata;

  assign imem.err   = rsp_live && (rsp_own_reg == OWN_IMEM) && m.err;
  assign dmem.err   = rsp_live && (rsp_own_reg == OWN_DMEM) && m.err;
  assign imem.rdata = (rsp_live && (rsp_own_reg == OWN_IMEM)) ? rsp_rdata : '0;
  assign dmem.rdata = (rsp_live && (rsp_own_reg == OWN_DMEM)) ? rsp_rdata : '0;

endmodule
